ft_alu_retry_scheduler: RTL

Shares one registered 16-bit fault-tolerant ALU between two requesters using round-robin arbitration. Each op is latched, issued to the ALU, and its registered result and error flag are checked one cycle later. On a detected error the op is re-issued, up to MAX_RETRY times. Each op produces one response carrying the result, a retry count and a fail flag, and the block keeps a saturating count of error events for fault monitoring.

---
 rtl/ft_alu_retry_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ft_alu_retry_scheduler.sv
// Round-robin scheduler sharing one registered fault-tolerant ALU between two requesters.
// Each op is issued, checked one cycle later, and re-issued on alu_error up to MAX_RETRY times.
module ft_alu_retry_scheduler #(
    parameter int W         = 16,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_W   = 2,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_opcode,
    input  logic [W-1:0]       req0_a,
    input  logic [W-1:0]       req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_opcode,
    input  logic [W-1:0]       req1_a,
    input  logic [W-1:0]       req1_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [W-1:0]       resp_result,
    output logic               resp_cout,
    output logic               resp_zero,
    output logic               resp_overflow,
    output logic               resp_fail,
    output logic [RETRY_W-1:0] resp_retries,
    output logic [W-1:0]       alu_operand_a,
    output logic [W-1:0]       alu_operand_b,
    output logic [3:0]         alu_opcode,
    input  logic [W-1:0]       alu_result,
    input  logic               alu_cout,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_error,
    input  logic               err_count_clr,
    output logic [CNT_W-1:0]   err_event_count,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;

    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

    state_t              state_reg, state_next;
    logic                last_grant_reg, last_grant_next;
    logic [RETRY_W-1:0]  retry_reg, retry_next;
    logic                id_reg;
    logic [3:0]          opcode_reg;
    logic [W-1:0]        a_reg, b_reg;
    logic                resp_id_reg, resp_cout_reg, resp_zero_reg, resp_overflow_reg, resp_fail_reg;
    logic [W-1:0]        resp_result_reg;
    logic [RETRY_W-1:0]  resp_retries_reg;
    logic [CNT_W-1:0]    err_count_reg;
    logic                grant0, grant1, exit_to_resp;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE) begin
            if (req0_valid && (!req1_valid || last_grant_reg)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        retry_next      = retry_reg;
        last_grant_next = last_grant_reg;
        exit_to_resp    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_next      = ISSUE;
                    retry_next      = '0;
                    last_grant_next = grant1;
                end
            end
            ISSUE: state_next = CHECK;
            CHECK: begin
                if (alu_error && (retry_reg < MAX_RETRY_V)) begin
                    retry_next = retry_reg + 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next   = RESP;
                    exit_to_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            retry_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            retry_reg      <= retry_next;
        end
    end

    // Latched op drives the ALU directly, so it stays stable until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg     <= 1'b0;
            opcode_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else if (grant0 || grant1) begin
            id_reg     <= grant1;
            opcode_reg <= grant1 ? req1_opcode : req0_opcode;
            a_reg      <= grant1 ? req1_a : req0_a;
            b_reg      <= grant1 ? req1_b : req0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_id_reg       <= 1'b0;
            resp_result_reg   <= '0;
            resp_cout_reg     <= 1'b0;
            resp_zero_reg     <= 1'b0;
            resp_overflow_reg <= 1'b0;
            resp_fail_reg     <= 1'b0;
            resp_retries_reg  <= '0;
        end else if (exit_to_resp) begin
            resp_id_reg       <= id_reg;
            resp_result_reg   <= alu_result;
            resp_cout_reg     <= alu_cout;
            resp_zero_reg     <= alu_zero;
            resp_overflow_reg <= alu_overflow;
            resp_fail_reg     <= alu_error;
            resp_retries_reg  <= retry_reg;
        end
    end

    // Clear has priority over a same-cycle error event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (err_count_clr) begin
            err_count_reg <= '0;
        end else if ((state_reg == CHECK) && alu_error && (err_count_reg != {CNT_W{1'b1}})) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign req0_ready      = grant0;
    assign req1_ready      = grant1;
    assign resp_valid      = (state_reg == RESP);
    assign resp_id         = resp_id_reg;
    assign resp_result     = resp_result_reg;
    assign resp_cout       = resp_cout_reg;
    assign resp_zero       = resp_zero_reg;
    assign resp_overflow   = resp_overflow_reg;
    assign resp_fail       = resp_fail_reg;
    assign resp_retries    = resp_retries_reg;
    assign alu_operand_a   = a_reg;
    assign alu_operand_b   = b_reg;
    assign alu_opcode      = opcode_reg;
    assign err_event_count = err_count_reg;
    assign busy            = (state_reg != IDLE);
endmodule
